// File: rtl/add_pipe.sv
// ---------------------------------------------------------------------------
// add_pipe
//   Pipelined two's-complement adder/subtractor. The WIDTH-bit carry chain is
//   cut into STAGES slices of SLICE = WIDTH/STAGES bits. Each stage adds one
//   slice and registers the partial result, its carry and the operand bits
//   that later stages still need. The pipeline advances as a whole whenever
//   the output register is empty or is being drained. Bubbles are kept, not
//   collapsed. Latency is STAGES cycles, and throughput is one operation per
//   cycle.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  pipeline depth, must divide WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valids and data)
//   in_valid   operands present
//   in_ready   pipeline can accept this cycle (= !out_valid || out_ready)
//   a, b       operands
//   cin        carry-in when adding, borrow-in when subtracting
//   sub        0 = a + b + cin, 1 = a - b - cin
//   out_valid  result present
//   out_ready  consumer takes the result this cycle
//   sum        result (mod 2^WIDTH, or saturated, see below)
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
//
// Build option
//   ADD_PIPE_SAT_EN  when defined, sum saturates to the signed limit on
//                    overflow. ovf and the raw cout are unaffected.
// ---------------------------------------------------------------------------
module add_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SLICE = WIDTH / STAGES;
   // Operand registers exist between stages only. Keep at least one entry
   // so the array stays legal when STAGES = 1.
   localparam int NOPS  = (STAGES > 1) ? STAGES - 1 : 1;

   logic                         w_adv;
   logic [WIDTH-1:0]             w_beff;
   logic                         w_cin_eff;
   logic [STAGES-1:0][WIDTH-1:0] w_res;
   logic [STAGES-1:0]            w_co;
   logic                         w_ovf;

   logic [STAGES-1:0]            r_vld;
   logic [STAGES-1:0][WIDTH-1:0] r_res;
   logic [STAGES-1:0]            r_cy;
   logic [NOPS-1:0][WIDTH-1:0]   r_opa;
   logic [NOPS-1:0][WIDTH-1:0]   r_opb;
   logic                         r_ovf;

   assign w_adv    = !r_vld[STAGES-1] || out_ready;
   assign in_ready = w_adv;

   // Subtract as a + ~b + !cin, so borrow-in becomes an inverted carry-in.
   assign w_beff    = sub ? ~b : b;
   assign w_cin_eff = sub ? ~cin : cin;

   // Per-stage slice adders. Stage k consumes slice k of the operands and
   // ORs its slice result into the partial sum handed on from stage k-1.
   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic [SLICE-1:0] w_sa;
      logic [SLICE-1:0] w_sb;
      logic [SLICE-1:0] w_s;
      logic             w_ci;
      logic [WIDTH-1:0] w_lo;

      if (k == 0) begin : g_first
         assign w_sa = SLICE'(a);
         assign w_sb = SLICE'(w_beff);
         assign w_ci = w_cin_eff;
         assign w_lo = '0;
      end else begin : g_next
         assign w_sa = SLICE'(r_opa[k-1] >> (k*SLICE));
         assign w_sb = SLICE'(r_opb[k-1] >> (k*SLICE));
         assign w_ci = r_cy[k-1];
         assign w_lo = r_res[k-1];
      end

      assign {w_co[k], w_s} = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, w_ci};
      assign w_res[k]       = w_lo | (WIDTH'(w_s) << (k*SLICE));

      if (k == STAGES - 1) begin : g_last
         // The carry into the MSB is recovered from the MSB sum bit:
         // s = a ^ b ^ c_in, so c_in = a ^ b ^ s.
         assign w_ovf = (w_sa[SLICE-1] ^ w_sb[SLICE-1] ^ w_s[SLICE-1]) ^ w_co[k];
      end
   end

   // All stage registers share one enable. When the output is stalled,
   // valids and data hold together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         r_res <= '0;
         r_cy  <= '0;
         r_opa <= '0;
         r_opb <= '0;
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_vld[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) r_vld[k] <= r_vld[k-1];
         r_res    <= w_res;
         r_cy     <= w_co;
         r_opa[0] <= a;
         r_opb[0] <= w_beff;
         for (int k = 1; k < NOPS; k++) begin
            r_opa[k] <= r_opa[k-1];
            r_opb[k] <= r_opb[k-1];
         end
         r_ovf    <= w_ovf;
      end
   end

   assign out_valid = r_vld[STAGES-1];
   assign cout      = r_cy[STAGES-1];
   assign ovf       = r_ovf;

`ifdef ADD_PIPE_SAT_EN
   // A raw MSB of 1 with overflow means the true result was too positive.
   // A raw MSB of 0 with overflow means it was too negative.
   assign sum = r_ovf ? {~r_res[STAGES-1][WIDTH-1], {(WIDTH-1){r_res[STAGES-1][WIDTH-1]}}}
                      : r_res[STAGES-1];
`else
   assign sum = r_res[STAGES-1];
`endif

endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;
   localparam int W = 16;
`ifdef ADD_PIPE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   always #5 clk = ~clk;

   add_pipe #(.WIDTH(W), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      res_t        r;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   res_t q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the unsigned and signed views.
   function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                  input logic ci, input logic sb);
      res_t r;
      int ux, uy, sx, sy, ur, sr;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (!sb) begin
         ur   = ux + uy + int'(ci);
         sr   = sx + sy + int'(ci);
         r.co = (ur > 65535);
      end else begin
         ur   = ux - uy - int'(ci);
         sr   = sx - sy - int'(ci);
         r.co = (ur >= 0);
      end
      r.s  = ur[15:0];
      r.ov = (sr > 32767) || (sr < -32768);
      if (SAT && r.ov) r.s = (sr > 0) ? 16'h7FFF : 16'h8000;
      return r;
   endfunction

   function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic ci,
                               input logic sb, input logic [15:0] s, input logic co,
                               input logic ov);
      vec_t v;
      v.a = x; v.b = y; v.cin = ci; v.sub = sb;
      v.r.s = s; v.r.co = co; v.r.ov = ov;
      return v;
   endfunction

   function automatic logic [15:0] pick();
      logic [15:0] c[5];
      c[0] = 16'h0000; c[1] = 16'hFFFF; c[2] = 16'h7FFF; c[3] = 16'h8000;
      c[4] = 16'($urandom);
      return c[$urandom_range(0, 6) > 4 ? 4 : $urandom_range(0, 4)];
   endfunction

   // Called just after a negedge, once inputs have settled. It scores any
   // output transfer and any accept that the coming posedge will perform.
   task automatic sb_step();
      res_t e;
      if (out_valid && out_ready) begin
         chk("sb_has_expect", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_sum", 32'(sum), 32'(e.s));
            chk("sb_cout", 32'(cout), 32'(e.co));
            chk("sb_ovf", 32'(ovf), 32'(e.ov));
         end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
      @(negedge clk);
   endtask

   // Single isolated operation. Starts at a negedge with an empty pipe and
   // measures latency in clock edges, counting from the accept edge.
   task automatic run_one(input vec_t v, input string nm);
      int lat;
      a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_lat"}, 32'(lat), 32'd4);
      chk({nm, "_sum"}, 32'(sum), 32'(v.r.s));
      chk({nm, "_cout"}, 32'(cout), 32'(v.r.co));
      chk({nm, "_ovf"}, 32'(ovf), 32'(v.r.ov));
      @(negedge clk);
      chk({nm, "_nodup"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[10];
      int          got;
      int          sent;
      int          cnt;
      logic [15:0] held;

      tbl[0] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      tbl[1] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);
      tbl[2] = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      tbl[3] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1);
      tbl[4] = mk(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      tbl[5] = mk(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      tbl[6] = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      tbl[7] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1);
      tbl[8] = mk(16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
      tbl[9] = mk(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1);

      // Reset state, with out_ready low so that in_ready must come from out_valid = 0
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 10; i++) run_one(tbl[i], $sformatf("vec%0d", i));

      // Streaming: 8 back-to-back accepts, results on 8 consecutive cycles
      got = 0;
      out_ready = 1'b1;
      for (int n = 0; n < 16; n++) begin
         if (out_valid) begin
            chk("stream_slot", 32'(n), 32'(4 + got));
            chk("stream_sum", 32'(sum), 32'(16'h0100 + got));
            got++;
         end
         if (n < 8) begin
            in_valid = 1'b1; a = 16'(n); b = 16'h0100; cin = 1'b0; sub = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("stream_count", 32'(got), 32'd8);

      // Backpressure: out_ready low for 3 cycles in the middle of a stream
      sent = 0;
      held = '0;
      for (int n = 0; n < 30; n++) begin
         out_ready = !(n >= 6 && n <= 8);
         if (sent < 10) begin
            in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (n >= 6 && n <= 8) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            if (n == 6) held = sum;
            else chk("bp_sum_hold", 32'(sum), 32'(held));
         end
         if (in_valid && in_ready) sent++;
         sb_step();
      end
      chk("bp_sent", 32'(sent), 32'd10);
      chk("bp_drained", 32'(q.size()), 32'd0);

      // Reset with three transactions in flight
      out_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
         #1;
         sb_step();
      end
      in_valid = 1'b0;
      #1;
      sb_step();
      out_ready = 1'b0;
      #1;
      chk("mid_pre_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_sum", 32'(sum), 32'd0);
      chk("mid_cout", 32'(cout), 32'd0);
      chk("mid_ovf", 32'(ovf), 32'd0);
      chk("mid_in_ready", 32'(in_ready), 32'd1);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      run_one(mk(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0), "post_rst");
      cnt = 0;
      for (int n = 0; n < 8; n++) begin
         if (out_valid) cnt++;
         @(negedge clk);
      end
      chk("post_rst_no_stale", 32'(cnt), 32'd0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 8);
         a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
         #1;
         sb_step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && q.size() != 0; n++) begin
         #1;
         sb_step();
      end
      chk("rand_drain", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
